// File: rtl/midi_pkg.sv
// Shared MIDI constants, FSM state type and priority-pick helper for midi_key_encoder.
package midi_pkg;

  localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
  localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;
  localparam logic [7:0] MIDI_REL_VEL  = 8'h40;

  typedef enum logic [1:0] {IDLE, STATUS, NOTE, VEL} midi_state_e;

  // Index of the lowest set bit; callers only use it when v != 0.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key bit: 2-flop synchroniser, then a run-length debouncer that flips the
// debounced level after DEBOUNCE_CYCLES consecutive differing samples.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_db
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync   <= '0;
      cnt    <= '0;
      key_db <= 1'b0;
    end else begin
      sync <= {sync[0], key_raw};
      if (sync[1] == key_db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        key_db <= ~key_db;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/midi_key_encoder.sv
// Eight debounced keys -> MIDI Note On/Off byte stream over a valid/ready handshake.
// Define MIDI_RUNNING_STATUS_EN for running status (release = Note On, velocity 0).
module midi_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int CHANNEL         = 0,
  parameter int BASE_NOTE       = 60,
  parameter int VELOCITY        = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] keys_i,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] key_state,
  output logic       busy
);
  import midi_pkg::*;

  localparam logic [7:0] CH   = {4'h0, 4'(CHANNEL)};
  localparam logic [6:0] BASE = 7'(BASE_NOTE);
  localparam logic [7:0] VON  = {1'b0, 7'(VELOCITY)};

  logic [7:0]  debounced, reported, pending;
  logic [2:0]  pick, idx;
  logic        on, hs, skip_status;
  logic [7:0]  status_byte, vel_byte, byte_nx;
  logic [6:0]  note;
  midi_state_e state, state_nx;

  for (genvar g = 0; g < 8; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .key_raw(keys_i[g]),
      .key_db (debounced[g])
    );
  end

  assign pending   = debounced ^ reported;
  assign pick      = lowest_set(pending);
  assign key_state = debounced;
  assign busy      = (state != IDLE);
  assign hs        = tx_valid & tx_ready;
  assign note      = BASE + {4'h0, idx};

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status;
  logic       last_vld;

  assign status_byte = MIDI_NOTE_ON | CH;
  assign vel_byte    = on ? VON : 8'h00;
  assign skip_status = last_vld && (last_status == status_byte);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_status <= '0;
      last_vld    <= 1'b0;
    end else if (state == STATUS && hs) begin
      last_status <= tx_data;
      last_vld    <= 1'b1;
    end
  end
`else
  assign status_byte = (on ? MIDI_NOTE_ON : MIDI_NOTE_OFF) | CH;
  assign vel_byte    = on ? VON : MIDI_REL_VEL;
  assign skip_status = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    byte_nx  = 8'h00;
    case (state)
      IDLE:    if (|pending) state_nx = skip_status ? NOTE : STATUS;
      STATUS:  if (hs) state_nx = NOTE;
      NOTE:    if (hs) state_nx = VEL;
      VEL:     if (hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    case (state_nx)
      STATUS:  byte_nx = status_byte;
      NOTE:    byte_nx = {1'b0, note};
      VEL:     byte_nx = vel_byte;
      default: byte_nx = 8'h00;
    endcase
  end

  // Output registers track the state one cycle late, so the first byte of a
  // message appears the cycle after capture and stalls simply reload the same byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      reported <= '0;
      idx      <= '0;
      on       <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |pending) begin
        idx            <= pick;
        on             <= debounced[pick];
        reported[pick] <= debounced[pick];
      end
      tx_valid <= (state != IDLE) && (state_nx != IDLE);
      if (state != IDLE) tx_data <= byte_nx;
    end
  end

endmodule

// File: doc/midi_key_encoder.md
# midi_key_encoder

Converts the eight raw GPIO key inputs of the system into MIDI Note On/Off byte streams for the UART transmitter. It sits between the gpio input pads and the uart TX byte interface. Each bit is synchronised, debounced and compared against the last reported state. The block then serialises one 3-byte (or 2-byte, running status) MIDI message per change over a valid/ready byte handshake.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 100: number of consecutive cycles a synchronised input must differ from the debounced state before the debounced state flips (≥1).
- `CHANNEL`, default 0: MIDI channel, 4 bits, ORed into the status nibble.
- `BASE_NOTE`, default 60: note number of key 0; key i sends `(BASE_NOTE + i) mod 128`.
- `VELOCITY`, default 100: Note On velocity, 7 bits.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `keys_i`  in  8  raw GPIO key levels, asynchronous, active-high = pressed.
- `tx_data`  out  8  MIDI byte to UART TX.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  UART accepts the byte this cycle when `tx_valid` is high.
- `key_state`  out  8  debounced key levels.
- `busy`  out  1  the FSM is not in IDLE.

## Operation
- Per bit: a 2-flop synchroniser feeds the debouncer.
  - The counter increments while the synchronised value ≠ `debounced[i]`, and clears on any cycle they are equal.
  - When the count reaches `DEBOUNCE_CYCLES-1` and the values still differ, `debounced[i]` flips on that edge and the count clears.
- `reported[8]` holds the last state sent. `pending = debounced ^ reported`.
- FSM states are IDLE, STATUS, NOTE, VEL.
  - IDLE: if `pending != 0`, capture the lowest set index i, latch `on = debounced[i]`, set `reported[i] = debounced[i]`, then go to STATUS. Otherwise stay in IDLE.
  - STATUS: drive the status byte. On handshake go to NOTE.
  - NOTE: drive `{0, note[6:0]}`. On handshake go to VEL.
  - VEL: drive the velocity byte. On handshake go to IDLE.
- Status byte: Note On = `8'h90 | CHANNEL`, Note Off = `8'h80 | CHANNEL`. Off velocity is `8'h40`.
- A press and release that both complete before the key is serviced cancel out (`pending` returns to 0), and no message is sent.
- A change on a key already being serialised is captured as a new pending event after the message finishes.
- Simultaneous changes are serviced lowest index first, one message each, with no byte interleaving.
- Reset values:
  - `tx_valid` = 0, `tx_data` = 0, `busy` = 0, `key_state` = 0.
  - `reported`, all counters and synchronisers are 0. The FSM is in IDLE.
- An asserted reset mid-message aborts the message immediately. No partial message is resumed.

## Timing
- Edge on `keys_i[i]` to `key_state[i]` flip: 2 sync cycles + `DEBOUNCE_CYCLES` cycles.
- `key_state` flip to `tx_valid` high with the status byte: 2 cycles (IDLE capture, then registered output).
- `tx_data`/`tx_valid` are registered and held stable while `tx_valid & ~tx_ready`.
- A new byte is presented in the cycle after each handshake. `tx_valid` stays high across the bytes of one message.
- Minimum IDLE time between messages: 1 cycle.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined:
  - Release is encoded as Note On with velocity 0.
  - A `last_status` register (reset value: invalid) is kept. If the new status equals `last_status`, STATUS is skipped and IDLE goes directly to NOTE.
  - `last_status` updates on each STATUS handshake.
- `MIDI_RUNNING_STATUS_EN` undefined: every message is 3 bytes, and release uses `8'h80` with velocity `8'h40`.

## Structure
- Package `midi_pkg`:
  - Status constants `MIDI_NOTE_ON = 8'h90` and `MIDI_NOTE_OFF = 8'h80`.
  - Release velocity constant `8'h40`.
  - FSM state enum.
- Sub-module `key_debounce` (one bit: synchroniser + counter + debounced flop, parameter `DEBOUNCE_CYCLES`), instantiated 8× in a generate loop.
- The top holds `reported`, the priority pick, the FSM and the output registers.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES = 4`, `CHANNEL = 0`, `BASE_NOTE = 60`, `VELOCITY = 100`, `tx_ready` tied to 1.

1. Hold `keys_i = 8'h01` for 10 cycles -> bytes `90 3C 64`. Release -> `80 3C 40`, or `3C 00` with running status enabled.
2. Apply 2-cycle glitches on bit 3 -> `key_state` is unchanged and no bytes are sent.
3. `keys_i` 00->`8'hAA` in one cycle -> four messages in order: notes `3D`, `3F`, `41`, `43`. With the macro, only the first message carries `90`.
4. Throttle `tx_ready` low for 5 cycles during the NOTE byte -> `tx_data` is held at `3C` and no byte is lost or duplicated.
5. Press key 7, release it before the message for key 0 finishes (key 0 pressed first) -> the only message is for key 0. No message is sent for key 7.
6. Assert `rst` low during the VEL byte -> `tx_valid` goes to 0 asynchronously. After release of reset, `key_state = 0` and no stale message is sent.
